// File: rtl/sync_fifo_buf.sv
// Single-clock FIFO buffer with registered read port, occupancy count, registered
// full/empty/threshold flags and sticky overflow/underflow error flags.
// Pointers carry one extra wrap bit; the low ADDR_WIDTH bits address the storage array.

module sync_fifo_buf #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = 6,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  // Count-width constants so every flag compare is width-matched.
  localparam logic [ADDR_WIDTH:0] DepthCnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AfLevel  = CntW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AeLevel  = CntW'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] PtrOne   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Storage is deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  wfull_q, wfull_d;
  logic                  rempty_q, rempty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  rd_ok;
  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  assign waddr = wptr_q[ADDR_WIDTH-1:0];
  assign raddr = rptr_q[ADDR_WIDTH-1:0];

  // Accept decisions; a read at full frees the slot a simultaneous write needs,
  // but a write at empty never feeds a simultaneous read (no bypass).
  always_comb begin
    rd_ok = ren & ~rempty_q;
    wr_ok = wen & (~wfull_q | rd_ok);
  end

  // Pointer and occupancy next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + PtrOne;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + PtrOne;
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + PtrOne;
      2'b01:   count_d = count_q - PtrOne;
      default: count_d = count_q;
    endcase
  end

  // Flags follow next-state count so they register coherently with count.
  always_comb begin
    wfull_d  = (count_d == DepthCnt);
    rempty_d = (count_d == '0);
    af_d     = (count_d >= AfLevel);
    ae_d     = (count_d <= AeLevel);
  end

  // Registered read port; rdata holds between reads.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_ok;
    if (rd_ok) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Sticky error flags; a new rejection in the err_clr cycle keeps the flag set.
  always_comb begin
    overflow_d  = err_clr ? 1'b0 : overflow_q;
    underflow_d = err_clr ? 1'b0 : underflow_q;
    if (wen & ~wr_ok) begin
      overflow_d = 1'b1;
    end
    if (ren & ~rd_ok) begin
      underflow_d = 1'b1;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      af_q        <= 1'b0;
      ae_q        <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wfull_q     <= wfull_d;
      rempty_q    <= rempty_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write; writes presented during reset are dropped.
  always_ff @(posedge wclk) begin
    if (!wrst && wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata        = rdata_q;
  assign rvalid       = rvalid_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_buf.sv
// Bench for sync_fifo_buf: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.

module tb_sync_fifo_buf;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          wrst, wen, ren, err_clr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_buf #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .wclk        (clk),
    .wrst        (wrst),
    .wen         (wen),
    .wdata       (wdata),
    .ren         (ren),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .wfull       (wfull),
    .rempty      (rempty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_rdata;
  bit            m_rvalid, m_ovf, m_udf, m_on;
  bit            m_rd, m_wr;

  always @(posedge clk) begin
    if (wrst) begin
      mq.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_on     = 1'b1;
    end else if (m_on) begin
      m_rd = ren && (mq.size() > 0);
      m_wr = wen && ((mq.size() < DEPTH) || m_rd);
      if (m_rd) m_rdata = mq.pop_front();
      if (m_wr) mq.push_back(wdata);
      m_rvalid = m_rd;
      if (err_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (wen && !m_wr) m_ovf = 1'b1;
      if (ren && !m_rd) m_udf = 1'b1;
    end
    #1;
    if (m_on) begin
      chk("mon_count", 32'(count), 32'(mq.size()));
      chk("mon_rdata", 32'(rdata), 32'(m_rdata));
      chk("mon_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("mon_wfull", 32'(wfull), 32'(mq.size() == DEPTH));
      chk("mon_rempty", 32'(rempty), 32'(mq.size() == 0));
      chk("mon_afull", 32'(almost_full), 32'(mq.size() >= AF));
      chk("mon_aempty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("mon_ovf", 32'(overflow), 32'(m_ovf));
      chk("mon_udf", 32'(underflow), 32'(m_udf));
    end
  end

  // Advance one clock; inputs change 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wen = 0; ren = 0; err_clr = 0; wrst = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    idle(); wen = 1; wdata = d; tick(); idle();
  endtask

  task automatic pop();
    idle(); ren = 1; tick(); idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst = 1; wen = 0; ren = 0; err_clr = 0; wdata = '0;
    tick(); tick();
    idle();
    chk("rst_count", 32'(count), 0);
    chk("rst_rempty", 32'(rempty), 1);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 1: fill with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i));
      chk("t1_count", 32'(count), 32'(i + 1));
      chk("t1_afull", 32'(almost_full), 32'(i + 1 >= 6));
      chk("t1_rempty", 32'(rempty), 0);
    end
    chk("t1_wfull", 32'(wfull), 1);

    // 2: drain in order
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("t2_rdata", 32'(rdata), 32'(8'h10 + i));
      chk("t2_rvalid", 32'(rvalid), 1);
      chk("t2_aempty", 32'(almost_empty), 32'(7 - i <= 1));
    end
    chk("t2_rempty", 32'(rempty), 1);
    tick();
    chk("t2_rvalid_low", 32'(rvalid), 0);
    chk("t2_rdata_hold", 32'(rdata), 32'h17);

    // 3: simultaneous write+read at full
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    idle(); wen = 1; ren = 1; wdata = 8'hAA; tick(); idle();
    chk("t3_count", 32'(count), 8);
    chk("t3_ovf", 32'(overflow), 0);
    chk("t3_rdata", 32'(rdata), 32'h20);
    for (int i = 0; i < 8; i++) pop();
    chk("t3_last", 32'(rdata), 32'hAA);
    chk("t3_rempty", 32'(rempty), 1);

    // 4: simultaneous write+read at empty, no bypass
    idle(); wen = 1; ren = 1; wdata = 8'h55; tick(); idle();
    chk("t4_udf", 32'(underflow), 1);
    chk("t4_count", 32'(count), 1);
    chk("t4_rvalid", 32'(rvalid), 0);
    pop();
    chk("t4_rdata", 32'(rdata), 32'h55);
    chk("t4_rvalid2", 32'(rvalid), 1);
    idle(); err_clr = 1; tick(); idle();
    chk("t4_udf_clr", 32'(underflow), 0);

    // 5: overflow and err_clr priority
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    push(8'hEE);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_count", 32'(count), 8);
    idle(); err_clr = 1; tick(); idle();
    chk("t5_ovf_clr", 32'(overflow), 0);
    idle(); err_clr = 1; wen = 1; wdata = 8'hEF; tick(); idle();
    chk("t5_ovf_win", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("t5_data", 32'(rdata), 32'(8'h30 + i));
    end
    idle(); err_clr = 1; tick(); idle();
    chk("t5_ovf_final", 32'(overflow), 0);

    // 6: streaming across pointer wrap, then reset mid-burst
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      idle(); wen = 1; ren = 1; wdata = 8'h50 + 8'(i); tick();
      chk("t6_data", 32'(rdata), (i < 4) ? 32'(8'h40 + i) : 32'(8'h50 + i - 4));
      chk("t6_count", 32'(count), 4);
    end
    wrst = 1; wen = 1; ren = 1; wdata = 8'hFF; tick(); idle();
    chk("t6_count_rst", 32'(count), 0);
    chk("t6_rempty_rst", 32'(rempty), 1);
    chk("t6_rvalid_rst", 32'(rvalid), 0);
    chk("t6_rdata_rst", 32'(rdata), 0);
    pop();
    chk("t6_udf_after", 32'(underflow), 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
